// File: rtl/fp_mul_pkg.sv
// ============================================================================
// Module  : fp_mul_pkg
// Brief   : Shared state encoding and constants for the FP multiply sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_mul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] FP_QNAN        = 32'h7FC00000;
    localparam int          BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/fp_mul_sequencer_if.sv
// ============================================================================
// Module  : fp_mul_sequencer_if
// Brief   : Operand, multiplier, transmitter and status signals of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_mul_sequencer_if;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ready;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_result;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        timeout_err;
    logic        err_clr;

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_result, tx_ready, err_clr,
        output in_ready, mul_start, mul_a, mul_b, tx_data, tx_valid,
               busy, done, overrun, timeout_err
    );

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_result, tx_ready, err_clr,
        input  in_ready, mul_start, mul_a, mul_b, tx_data, tx_valid,
               busy, done, overrun, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/fp_word_serializer.sv
// ============================================================================
// Module  : fp_word_serializer
// Brief   : Holds a 32-bit word and streams it MSB-first as bytes over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_word_serializer
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_accept
);
    localparam int                  IDX_W    = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [31:0]      word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             accept;
    logic [31:0]      word_shifted;

    always_comb begin
        word_d      = word_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        accept      = valid_q && tx_ready;
        last_accept = accept && (idx_q == LAST_IDX);
        if (load) begin
            word_d  = load_word;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
            if (last_accept) begin
                idx_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // Shifting the current byte to the top avoids a variable part-select.
    assign word_shifted = word_q << {idx_q, 3'b000};
    assign tx_data      = word_shifted[31:24];
    assign tx_valid     = valid_q;

endmodule

`default_nettype wire

// File: rtl/fp_mul_sequencer.sv
// ============================================================================
// Module  : fp_mul_sequencer
// Brief   : Launches one FP multiply per operand pair, with timeout, and sends the result bytewise.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_sequencer
    import fp_mul_pkg::*;
#(
    parameter int          TIMEOUT     = 64,
    parameter logic [31:0] NAN_PATTERN = FP_QNAN
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_mul_sequencer_if.slave   bus
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic        timeout_set;
    logic        load;
    logic [31:0] load_word;
    logic        last_accept;
    logic [7:0]  tx_data;
    logic        tx_valid;

    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        load_word   = bus.mul_result;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mul_a_d = bus.in_a;
                    mul_b_d = bus.in_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A done arriving on the expiry cycle still delivers the real product.
                if (bus.mul_done) begin
                    load    = 1'b1;
                    state_d = SEND;
                end else if (cnt_q == CNT_LAST) begin
                    load        = 1'b1;
                    load_word   = NAN_PATTERN;
                    timeout_set = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (last_accept) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        overrun_d = (bus.in_valid && (state_q != IDLE)) || (overrun_q && !bus.err_clr);
        timeout_d = timeout_set || (timeout_q && !bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    fp_word_serializer u_serializer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_word   (load_word),
        .tx_ready    (bus.tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .last_accept (last_accept)
    );

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.mul_start   = (state_q == ISSUE);
    assign bus.done        = (state_q == DONE);
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.tx_data     = tx_data;
    assign bus.tx_valid    = tx_valid;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_q;

endmodule

`default_nettype wire
